// File: rtl/vending_credit_fsm.sv
// Vending-machine credit controller: synchronises buttons, accumulates credit in 5-cent
// units, vends at PRICE and returns change one unit at a time.
module vending_credit_fsm #(
  parameter int unsigned PRICE         = 4,
  parameter int unsigned VEND_CYCLES   = 25_000_000,
  parameter int unsigned CHANGE_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       quarter_in,
  input  logic       cancel_in,
  output logic [3:0] credit_disp,
  output logic       dispense,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       busy
);

  localparam int unsigned MaxCycles = (VEND_CYCLES > CHANGE_CYCLES) ? VEND_CYCLES : CHANGE_CYCLES;
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [TimerW-1:0] VendLast   = TimerW'(VEND_CYCLES - 1);
  localparam logic [TimerW-1:0] ChangeLast = TimerW'(CHANGE_CYCLES - 1);
  localparam logic [3:0]        Price      = 4'(PRICE);

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

  state_e            state_q, state_d;
  logic [3:0]        credit_q, credit_d;
  logic [3:0]        remaining_q, remaining_d;
  logic [TimerW-1:0] timer_q, timer_d;

  // Button bit order: {cancel, quarter, dime, nickel}
  logic [3:0] btn_raw, sync1_q, sync2_q, prev_q, press;

  logic [3:0] coin_val;
  logic       coin_any, coin_extra, cancel_p;
  logic [4:0] sum;
  logic       reject, pulse;
  logic [3:0] disp_d;

  assign btn_raw = {cancel_in, quarter_in, dime_in, nickel_in};
  assign press   = sync2_q & ~prev_q;

  // Only the highest-priority coin is evaluated; any lower coin alongside it is refused
  always_comb begin
    coin_val   = 4'd0;
    coin_extra = 1'b0;
    if (press[2]) begin
      coin_val   = 4'd5;
      coin_extra = press[1] | press[0];
    end else if (press[1]) begin
      coin_val   = 4'd2;
      coin_extra = press[0];
    end else if (press[0]) begin
      coin_val   = 4'd1;
    end
  end

  assign coin_any = |press[2:0];
  assign cancel_p = press[3];
  assign sum      = {1'b0, credit_q} + {1'b0, coin_val};

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    remaining_d = remaining_q;
    timer_d     = '0;
    reject      = 1'b0;
    pulse       = 1'b0;

    unique case (state_q)
      StIdle, StCollect: begin
        if (cancel_p) begin
          reject = coin_any;
          if (state_q == StCollect) begin
            state_d     = StChange;
            remaining_d = credit_q;
          end
        end else if (coin_any) begin
          reject = coin_extra;
          if (sum <= 5'd8) begin
            credit_d = sum[3:0];
            state_d  = (sum >= {1'b0, Price}) ? StVend : StCollect;
          end else begin
            reject = 1'b1;
          end
        end
      end
      StVend: begin
        reject  = coin_any;
        timer_d = timer_q + TimerW'(1);
        if (timer_q == VendLast) begin
          remaining_d = credit_q - Price;
          if (credit_q == Price) begin
            state_d  = StIdle;
            credit_d = 4'd0;
          end else begin
            state_d = StChange;
          end
        end
      end
      StChange: begin
        reject  = coin_any;
        timer_d = timer_q + TimerW'(1);
        if (timer_q == ChangeLast) begin
          pulse       = 1'b1;
          remaining_d = remaining_q - 4'd1;
          timer_d     = '0;
          if (remaining_q == 4'd1) begin
            state_d  = StIdle;
            credit_d = 4'd0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) timer_d = '0;
    disp_d = (state_d == StChange) ? remaining_d : credit_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      credit_q     <= 4'd0;
      remaining_q  <= 4'd0;
      timer_q      <= '0;
      sync1_q      <= 4'd0;
      sync2_q      <= 4'd0;
      prev_q       <= 4'd0;
      credit_disp  <= 4'd0;
      dispense     <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      remaining_q  <= remaining_d;
      timer_q      <= timer_d;
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      credit_disp  <= disp_d;
      dispense     <= (state_d == StVend);
      change_pulse <= pulse;
      coin_reject  <= reject;
      busy         <= (state_d == StVend) || (state_d == StChange);
    end
  end

endmodule
